// File: rtl/dense_layer_tm_if.sv
// Start/busy/done handshake plus the operand and result arrays of dense_layer_tm.
// The master drives operands and start; the slave (the layer) returns results.
interface dense_layer_tm_if #(
    parameter int NEURON_NB = 32,
    parameter int IN_SIZE   = 196,
    parameter int WIDTH     = 8
);
    logic                      start;
    logic signed [2*WIDTH-1:0] in_data    [0:IN_SIZE-1];
    logic signed [WIDTH-1:0]   weights    [0:NEURON_NB-1][0:IN_SIZE-1];
    logic signed [WIDTH-1:0]   biases     [0:NEURON_NB-1];
    logic signed [4*WIDTH-1:0] neuron_out [0:NEURON_NB-1];
    logic                      busy;
    logic                      layer_done;

    modport master (
        output start, in_data, weights, biases,
        input  neuron_out, busy, layer_done
    );

    modport slave (
        input  start, in_data, weights, biases,
        output neuron_out, busy, layer_done
    );
endinterface

// File: rtl/dense_layer_tm.sv
// Time-multiplexed dense layer: LANES MAC lanes walk the neurons in groups,
// one input element per cycle, with optional ReLU on the stored results.
module dense_layer_tm #(
    parameter int NEURON_NB = 32,
    parameter int IN_SIZE   = 196,
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int RELU_EN   = 1
) (
    input  logic            clk,
    input  logic            reset,
    dense_layer_tm_if.slave bus
);
    localparam int G  = NEURON_NB / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int NW = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
    localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int PW = 3 * WIDTH;
    localparam int AW = 4 * WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, DONE} state_t;

    state_t               state, state_nx;
    logic [GW-1:0]        g;
    logic [NW-1:0]        base;
    logic [KW-1:0]        k;
    logic signed [AW-1:0] acc  [LANES];
    logic signed [PW-1:0] prod [LANES];
    logic                 last_k, last_g;

    assign last_k = (k == KW'(IN_SIZE - 1));
    assign last_g = (g == GW'(G - 1));

    // base tracks g*LANES so the neuron index never needs a multiplier
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            prod[l] = PW'(bus.in_data[k]) * PW'(bus.weights[base + NW'(l)][k]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nx = LOAD;
            LOAD:       state_nx = MAC;
            MAC:        if (last_k) state_nx = STORE;
            STORE:      state_nx = last_g ? DONE : LOAD;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g              <= '0;
            base           <= '0;
            k              <= '0;
            acc            <= '{default: '0};
            bus.neuron_out <= '{default: '0};
            bus.busy       <= 1'b0;
            bus.layer_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        g              <= '0;
                        base           <= '0;
                        bus.busy       <= 1'b1;
                        bus.layer_done <= 1'b0;
                    end
                end
                LOAD: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        acc[l] <= AW'(bus.biases[base + NW'(l)]);
                    end
                    k <= '0;
                end
                MAC: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        acc[l] <= acc[l] + AW'(prod[l]);
                    end
                    if (!last_k) k <= k + 1'b1;
                end
                STORE: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        bus.neuron_out[base + NW'(l)] <=
                            (RELU_EN != 0 && acc[l][AW-1]) ? '0 : acc[l];
                    end
                    if (last_g) begin
                        bus.busy       <= 1'b0;
                        bus.layer_done <= 1'b1;
                    end else begin
                        g    <= g + 1'b1;
                        base <= base + NW'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_tm.sv
// Bench for dense_layer_tm: three configurations (ReLU on, ReLU off, single
// group) driven with identical operands and checked against an arithmetic model.
module tb_dense_layer_tm;
    localparam int NN = 4;
    localparam int IS = 3;
    localparam int W  = 8;

    logic clk;
    logic reset;
    logic start;
    logic signed [2*W-1:0] in_data [0:IS-1];
    logic signed [W-1:0]   weights [0:NN-1][0:IS-1];
    logic signed [W-1:0]   biases  [0:NN-1];

    int vectors;
    int miscompares;

    logic signed [31:0] exp_r [NN];
    logic signed [31:0] exp_n [NN];
    logic signed [31:0] prev_r [NN];
    logic signed [31:0] mid_a [NN];

    dense_layer_tm_if #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(W)) ifa ();
    dense_layer_tm_if #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(W)) ifb ();
    dense_layer_tm_if #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(W)) ifc ();

    assign ifa.start = start;  assign ifa.in_data = in_data;
    assign ifa.weights = weights;  assign ifa.biases = biases;
    assign ifb.start = start;  assign ifb.in_data = in_data;
    assign ifb.weights = weights;  assign ifb.biases = biases;
    assign ifc.start = start;  assign ifc.in_data = in_data;
    assign ifc.weights = weights;  assign ifc.biases = biases;

    dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(W), .LANES(2), .RELU_EN(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(W), .LANES(2), .RELU_EN(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    dense_layer_tm #(.NEURON_NB(NN), .IN_SIZE(IS), .WIDTH(W), .LANES(4), .RELU_EN(1))
        dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Dot product plus bias in wide arithmetic, then wrapped to 32 bits
    task automatic compute_model();
        for (int n = 0; n < NN; n++) begin
            longint s;
            s = longint'(biases[n]);
            for (int i = 0; i < IS; i++)
                s += longint'(in_data[i]) * longint'(weights[n][i]);
            exp_n[n] = s[31:0];
            exp_r[n] = (exp_n[n] < 0) ? 32'sd0 : exp_n[n];
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int n = 0; n < NN; n++) begin
            check($sformatf("%s_a%0d", tag, n), ifa.neuron_out[n], exp_r[n]);
            check($sformatf("%s_b%0d", tag, n), ifb.neuron_out[n], exp_n[n]);
            check($sformatf("%s_c%0d", tag, n), ifc.neuron_out[n], exp_r[n]);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy_a"}, 32'(ifa.busy), 0);
        check({tag, "_done_a"}, 32'(ifa.layer_done), 0);
        check({tag, "_busy_c"}, 32'(ifc.busy), 0);
        check({tag, "_done_b"}, 32'(ifb.layer_done), 0);
        for (int n = 0; n < NN; n++) begin
            check($sformatf("%s_out_a%0d", tag, n), ifa.neuron_out[n], 0);
            check($sformatf("%s_out_b%0d", tag, n), ifb.neuron_out[n], 0);
        end
    endtask

    // Start sampled at the next edge (edge 0); optional extra start before edge `extra`
    task automatic run(input string tag, input int extra);
        int lat_a, lat_c, busy_a;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_e0_done"}, 32'(ifa.layer_done), 0);
        check({tag, "_e0_busy"}, 32'(ifa.busy), 1);
        lat_a = -1; lat_c = -1;
        busy_a = ifa.busy ? 1 : 0;
        for (int c = 1; c <= 40 && lat_a < 0; c++) begin
            if (c == extra) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            if (c == IS + 2)
                for (int n = 0; n < NN; n++) mid_a[n] = ifa.neuron_out[n];
            if (ifa.busy) busy_a++;
            if (lat_c < 0 && ifc.layer_done) lat_c = c;
            if (lat_a < 0 && ifa.layer_done) lat_a = c;
        end
        check({tag, "_lat_a"}, lat_a, 2 * (IS + 2));
        check({tag, "_lat_c"}, lat_c, IS + 2);
        check({tag, "_busy_cycles"}, busy_a, 2 * (IS + 2));
        check({tag, "_busy_end"}, 32'(ifa.busy), 0);
        check({tag, "_done_b"}, 32'(ifb.layer_done), 1);
    endtask

    task automatic load_basic();
        in_data[0] = 1; in_data[1] = 2; in_data[2] = 3;
        weights[0][0] = 1;  weights[0][1] = 1;  weights[0][2] = 1;
        weights[1][0] = -1; weights[1][1] = -1; weights[1][2] = -1;
        weights[2][0] = 2;  weights[2][1] = 0;  weights[2][2] = 1;
        weights[3][0] = 0;  weights[3][1] = 0;  weights[3][2] = 0;
        biases[0] = 4; biases[1] = 0; biases[2] = -5; biases[3] = 7;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        load_basic();
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        compute_model();
        run("basic", 0);
        check_outputs("basic");

        run("busy_start", 4);
        check_outputs("busy_start");

        // One idle edge after done, so the re-run start lands in DONE
        @(posedge clk); #1;
        run("done_restart", 0);
        check_outputs("done_restart");

        for (int i = 0; i < IS; i++) in_data[i] = -16'sd32768;
        for (int n = 0; n < NN; n++) begin
            biases[n] = 8'sd127;
            for (int i = 0; i < IS; i++) weights[n][i] = -8'sd128;
        end
        compute_model();
        run("extreme", 0);
        check_outputs("extreme");

        for (int r = 0; r < 8; r++) begin
            int extra;
            for (int n = 0; n < NN; n++) prev_r[n] = exp_r[n];
            for (int i = 0; i < IS; i++) in_data[i] = 16'($urandom);
            for (int n = 0; n < NN; n++) begin
                biases[n] = 8'($urandom);
                for (int i = 0; i < IS; i++) weights[n][i] = 8'($urandom);
            end
            compute_model();
            extra = (r % 2 == 0) ? 0 : int'($urandom_range(2, 4));
            run($sformatf("rand%0d", r), extra);
            check_outputs($sformatf("rand%0d", r));
            for (int n = 0; n < NN; n++)
                check($sformatf("rand%0d_mid%0d", r, n), mid_a[n],
                      (n < 2) ? exp_r[n] : prev_r[n]);
        end

        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_idle_zero("async_reset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_idle_zero("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
